// File: rtl/param_stream_checker.sv
// Receive-side stream checker: compares valid beats against EXPECT_DATA under DATA_MASK, tracks lock and keeps saturating statistics.
// Optional macro PARAM_STREAM_CHECKER_STICKY_EN builds the sticky error flag; otherwise err_sticky is tied low.
module param_stream_checker #(
    parameter bit [7:0] EXPECT_DATA = 8'hAB,
    parameter bit [7:0] DATA_MASK   = 8'hFF,
    parameter int       LOCK_COUNT  = 4,
    parameter int       LOSS_COUNT  = 2,
    parameter int       CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             locked,
    output logic [1:0]       state,
    output logic             err_pulse,
    output logic [CNT_W-1:0] match_cnt,
    output logic [CNT_W-1:0] mismatch_cnt,
    output logic             err_sticky
);

    typedef enum logic [1:0] {
        SEARCH   = 2'd0,
        ACQUIRE  = 2'd1,
        LOCKED   = 2'd2,
        DEGRADED = 2'd3
    } state_t;

    localparam int RUN_W  = $clog2(LOCK_COUNT + 1);
    localparam int MISS_W = $clog2(LOSS_COUNT + 1);

    state_t            state_q, state_next;
    logic [RUN_W-1:0]  run_q, run_next;
    logic [MISS_W-1:0] miss_q, miss_next;
    logic              err_next;
    logic              match;

    assign match = ((in_data ^ EXPECT_DATA) & DATA_MASK) == 8'h00;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= SEARCH;
            run_q        <= '0;
            miss_q       <= '0;
            err_pulse    <= 1'b0;
            match_cnt    <= '0;
            mismatch_cnt <= '0;
        end else if (clear) begin
            state_q      <= SEARCH;
            run_q        <= '0;
            miss_q       <= '0;
            err_pulse    <= 1'b0;
            match_cnt    <= '0;
            mismatch_cnt <= '0;
        end else begin
            state_q   <= state_next;
            run_q     <= run_next;
            miss_q    <= miss_next;
            err_pulse <= err_next;
            // Statistics saturate at all-ones rather than wrapping.
            if (in_valid && match && (match_cnt != '1))
                match_cnt <= match_cnt + 1'b1;
            if (in_valid && !match && (mismatch_cnt != '1))
                mismatch_cnt <= mismatch_cnt + 1'b1;
        end
    end

    always_comb begin
        state_next = state_q;
        run_next   = run_q;
        miss_next  = miss_q;
        err_next   = 1'b0;
        if (in_valid) begin
            case (state_q)
                SEARCH: begin
                    if (match) begin
                        if (LOCK_COUNT == 1) begin
                            state_next = LOCKED;
                            run_next   = '0;
                        end else begin
                            state_next = ACQUIRE;
                            run_next   = RUN_W'(1);
                        end
                    end
                end
                ACQUIRE: begin
                    if (match) begin
                        if (int'(run_q) + 1 >= LOCK_COUNT) begin
                            state_next = LOCKED;
                            run_next   = '0;
                        end else begin
                            run_next = run_q + 1'b1;
                        end
                    end else begin
                        state_next = SEARCH;
                        run_next   = '0;
                    end
                end
                LOCKED: begin
                    if (!match) begin
                        err_next = 1'b1;
                        if (LOSS_COUNT == 1) begin
                            state_next = SEARCH;
                            miss_next  = '0;
                        end else begin
                            state_next = DEGRADED;
                            miss_next  = MISS_W'(1);
                        end
                    end
                end
                default: begin
                    err_next = !match;
                    if (match) begin
                        state_next = LOCKED;
                        miss_next  = '0;
                    end else if (int'(miss_q) + 1 >= LOSS_COUNT) begin
                        state_next = SEARCH;
                        miss_next  = '0;
                    end else begin
                        miss_next = miss_q + 1'b1;
                    end
                end
            endcase
        end
    end

    always_comb begin
        state  = state_q;
        locked = (state_q == LOCKED) || (state_q == DEGRADED);
    end

`ifdef PARAM_STREAM_CHECKER_STICKY_EN
    logic sticky_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sticky_q <= 1'b0;
        else if (clear)
            sticky_q <= 1'b0;
        else if (err_next)
            sticky_q <= 1'b1;
    end

    assign err_sticky = sticky_q;
`else
    assign err_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_param_stream_checker.sv
// Bench for param_stream_checker: three parameterisations share one input stream, each tracked by a lock/statistics model.
// Vector table and hand sequences cover the lock corner cases; a randomized phase follows.
module tb_param_stream_checker;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clear = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;

    logic        d0_locked, d0_err, d0_sticky;
    logic [1:0]  d0_state;
    logic [15:0] d0_mc, d0_mmc;
    logic        d1_locked, d1_err, d1_sticky;
    logic [1:0]  d1_state;
    logic [1:0]  d1_mc, d1_mmc;
    logic        d2_locked, d2_err, d2_sticky;
    logic [1:0]  d2_state;
    logic [15:0] d2_mc, d2_mmc;

    int checks = 0;
    int failures = 0;

`ifdef PARAM_STREAM_CHECKER_STICKY_EN
    localparam bit STICKY_ON = 1'b1;
`else
    localparam bit STICKY_ON = 1'b0;
`endif

    always #5 clk = ~clk;

    param_stream_checker dut0 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_data(in_data),
        .locked(d0_locked), .state(d0_state), .err_pulse(d0_err),
        .match_cnt(d0_mc), .mismatch_cnt(d0_mmc), .err_sticky(d0_sticky)
    );

    param_stream_checker #(.CNT_W(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_data(in_data),
        .locked(d1_locked), .state(d1_state), .err_pulse(d1_err),
        .match_cnt(d1_mc), .mismatch_cnt(d1_mmc), .err_sticky(d1_sticky)
    );

    param_stream_checker #(.DATA_MASK(8'hF0)) dut2 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_data(in_data),
        .locked(d2_locked), .state(d2_state), .err_pulse(d2_err),
        .match_cnt(d2_mc), .mismatch_cnt(d2_mmc), .err_sticky(d2_sticky)
    );

    // Model: a lock flag plus consecutive-match and consecutive-miss tallies.
    typedef struct {
        bit lk;
        int run;
        int miss;
        bit err;
        int mc;
        int mmc;
        bit sticky;
    } model_t;

    typedef struct {
        logic       clr;
        logic       vld;
        logic [7:0] data;
        logic [1:0] st;
        logic       lk;
        logic       err;
        int         mc;
        int         mmc;
    } vec_t;

    model_t m0, m1, m2;

    function automatic model_t modelStep(model_t m, bit [7:0] mask, int maxc,
                                         bit clr, bit vld, bit [7:0] data);
        model_t n;
        bit hit;
        n = m;
        n.err = 1'b0;
        if (clr) begin
            n = '{lk: 1'b0, run: 0, miss: 0, err: 1'b0, mc: 0, mmc: 0, sticky: 1'b0};
        end else if (vld) begin
            hit = ((data ^ 8'hAB) & mask) == 8'h00;
            if (hit) n.mc = (m.mc < maxc) ? m.mc + 1 : maxc;
            else     n.mmc = (m.mmc < maxc) ? m.mmc + 1 : maxc;
            if (!m.lk) begin
                n.run = hit ? m.run + 1 : 0;
                if (n.run >= 4) begin
                    n.lk = 1'b1;
                    n.run = 0;
                end
            end else if (hit) begin
                n.miss = 0;
            end else begin
                n.err = 1'b1;
                n.sticky = 1'b1;
                n.miss = m.miss + 1;
                if (n.miss >= 2) begin
                    n.lk = 1'b0;
                    n.miss = 0;
                end
            end
        end
        return n;
    endfunction

    function automatic int expState(model_t m);
        if (!m.lk) return (m.run == 0) ? 0 : 1;
        return (m.miss == 0) ? 2 : 3;
    endfunction

    function automatic model_t modelReset();
        return '{lk: 1'b0, run: 0, miss: 0, err: 1'b0, mc: 0, mmc: 0, sticky: 1'b0};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkDut(input string tag, input model_t m,
                            input logic [1:0] st, input logic lk, input logic er,
                            input logic [31:0] mc, input logic [31:0] mmc, input logic sk);
        checkOutput({tag, ".state"}, 32'(st), 32'(expState(m)));
        checkOutput({tag, ".locked"}, 32'(lk), 32'(m.lk));
        checkOutput({tag, ".err_pulse"}, 32'(er), 32'(m.err));
        checkOutput({tag, ".match_cnt"}, mc, 32'(m.mc));
        checkOutput({tag, ".mismatch_cnt"}, mmc, 32'(m.mmc));
        checkOutput({tag, ".err_sticky"}, 32'(sk), 32'(STICKY_ON & m.sticky));
    endtask

    task automatic compareAll();
        checkDut("dut0", m0, d0_state, d0_locked, d0_err, 32'(d0_mc), 32'(d0_mmc), d0_sticky);
        checkDut("dut1", m1, d1_state, d1_locked, d1_err, 32'(d1_mc), 32'(d1_mmc), d1_sticky);
        checkDut("dut2", m2, d2_state, d2_locked, d2_err, 32'(d2_mc), 32'(d2_mmc), d2_sticky);
    endtask

    task automatic applyStimulus(input bit clr, input bit vld, input bit [7:0] data);
        @(negedge clk);
        clear = clr;
        in_valid = vld;
        in_data = data;
        @(posedge clk);
        #1;
        m0 = modelStep(m0, 8'hFF, 65535, clr, vld, data);
        m1 = modelStep(m1, 8'hFF, 3, clr, vld, data);
        m2 = modelStep(m2, 8'hF0, 65535, clr, vld, data);
        compareAll();
    endtask

    task automatic doReset();
        @(negedge clk);
        in_valid = 1'b0;
        clear = 1'b0;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset.state", 32'(d0_state), 32'd0);
        checkOutput("async_reset.locked", 32'(d0_locked), 32'd0);
        checkOutput("async_reset.match_cnt", 32'(d0_mc), 32'd0);
        m0 = modelReset();
        m1 = modelReset();
        m2 = modelReset();
        #2;
        rst_n = 1'b1;
        compareAll();
    endtask

    initial begin
        vec_t vecs[$];
        m0 = modelReset();
        m1 = modelReset();
        m2 = modelReset();

        vecs.push_back('{1'b0, 1'b1, 8'hAB, 2'd1, 1'b0, 1'b0, 1, 0});
        vecs.push_back('{1'b0, 1'b1, 8'hAB, 2'd1, 1'b0, 1'b0, 2, 0});
        vecs.push_back('{1'b0, 1'b1, 8'hAB, 2'd1, 1'b0, 1'b0, 3, 0});
        vecs.push_back('{1'b0, 1'b1, 8'hAB, 2'd2, 1'b1, 1'b0, 4, 0});
        vecs.push_back('{1'b0, 1'b1, 8'h00, 2'd3, 1'b1, 1'b1, 4, 1});
        vecs.push_back('{1'b0, 1'b1, 8'hAB, 2'd2, 1'b1, 1'b0, 5, 1});
        vecs.push_back('{1'b0, 1'b0, 8'h00, 2'd2, 1'b1, 1'b0, 5, 1});
        vecs.push_back('{1'b0, 1'b1, 8'h00, 2'd3, 1'b1, 1'b1, 5, 2});
        vecs.push_back('{1'b0, 1'b1, 8'h01, 2'd0, 1'b0, 1'b1, 5, 3});
        vecs.push_back('{1'b1, 1'b1, 8'hAB, 2'd0, 1'b0, 1'b0, 0, 0});
        vecs.push_back('{1'b0, 1'b1, 8'hAB, 2'd1, 1'b0, 1'b0, 1, 0});
        vecs.push_back('{1'b0, 1'b1, 8'hAB, 2'd1, 1'b0, 1'b0, 2, 0});
        vecs.push_back('{1'b0, 1'b1, 8'hAB, 2'd1, 1'b0, 1'b0, 3, 0});
        vecs.push_back('{1'b0, 1'b1, 8'h00, 2'd0, 1'b0, 1'b0, 3, 1});
        vecs.push_back('{1'b0, 1'b1, 8'hAB, 2'd1, 1'b0, 1'b0, 4, 1});
        vecs.push_back('{1'b0, 1'b1, 8'hAB, 2'd1, 1'b0, 1'b0, 5, 1});
        vecs.push_back('{1'b0, 1'b1, 8'hAB, 2'd1, 1'b0, 1'b0, 6, 1});
        vecs.push_back('{1'b0, 1'b1, 8'hAB, 2'd2, 1'b1, 1'b0, 7, 1});

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset.state", 32'(d0_state), 32'd0);
        checkOutput("reset.err_pulse", 32'(d0_err), 32'd0);
        checkOutput("reset.mismatch_cnt", 32'(d0_mmc), 32'd0);
        checkOutput("reset.err_sticky", 32'(d0_sticky), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].clr, vecs[i].vld, vecs[i].data);
            checkOutput($sformatf("vec%0d.state", i), 32'(d0_state), 32'(vecs[i].st));
            checkOutput($sformatf("vec%0d.locked", i), 32'(d0_locked), 32'(vecs[i].lk));
            checkOutput($sformatf("vec%0d.err_pulse", i), 32'(d0_err), 32'(vecs[i].err));
            checkOutput($sformatf("vec%0d.match_cnt", i), 32'(d0_mc), 32'(vecs[i].mc));
            checkOutput($sformatf("vec%0d.mismatch_cnt", i), 32'(d0_mmc), 32'(vecs[i].mmc));
        end

        // Reset while locked; lock must be re-earned with a full run.
        doReset();
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 8'hAB);
        checkOutput("relock.not_yet", 32'(d0_locked), 32'd0);
        applyStimulus(1'b0, 1'b1, 8'hAB);
        checkOutput("relock.locked", 32'(d0_locked), 32'd1);
        applyStimulus(1'b0, 1'b1, 8'hAB);
        checkOutput("sat.cnt_w2", 32'(d1_mc), 32'd3);

        applyStimulus(1'b0, 1'b1, 8'h00);
        checkOutput("sticky.err_pulse", 32'(d0_err), 32'd1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 8'hAB);
        checkOutput("sticky.held", 32'(d0_sticky), 32'(STICKY_ON));
        applyStimulus(1'b1, 1'b1, 8'hAB);
        checkOutput("clear.sticky", 32'(d0_sticky), 32'd0);
        checkOutput("clear.match_cnt", 32'(d0_mc), 32'd0);
        checkOutput("clear.state", 32'(d0_state), 32'd0);

        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 8'hA5);
        checkOutput("mask.match_cnt", 32'(d2_mc), 32'd4);
        checkOutput("mask.locked", 32'(d2_locked), 32'd1);
        checkOutput("mask.dut0_mismatch", 32'(d0_mmc), 32'd4);

        for (int i = 0; i < 600; i++) begin
            bit [7:0] d;
            int sel;
            sel = $urandom_range(0, 9);
            d = (sel < 5) ? 8'hAB : (sel < 8) ? 8'hA5 : 8'($urandom);
            applyStimulus($urandom_range(0, 60) == 0, $urandom_range(0, 4) != 0, d);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
